sm_neuron_accum: RTL and testbench



---
 rtl/sm_neuron_accum.sv | 136 +++++++++++++
 tb/tb_sm_neuron_accum.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/sm_neuron_accum.sv
// Sign-magnitude neuron accumulator: sums a stream of partial sums and presents a
// saturated result through a valid/ready handshake. Optional ReLU: SM_NEURON_ACCUM_RELU_EN.
module sm_neuron_accum #(
  parameter int IN_W  = 9,
  parameter int ACC_W = 16,
  parameter int OUT_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic [IN_W-1:0]  iData,
  input  logic             iValid,
  input  logic             iLast,
  output logic             oInReady,
  output logic [OUT_W-1:0] oResult,
  output logic             oValid,
  input  logic             iReady,
  output logic             oSat,
  output logic             oOvf,
  output logic [CNT_W-1:0] oCount
);

  localparam int MW = ACC_W - 1;

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  state_t           state;
  logic             acc_sign;
  logic [MW-1:0]    acc_mag;
  logic             ovf;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic             base_sign;
  logic [MW-1:0]    base_mag;
  logic             term_sign;
  logic [MW-1:0]    term_mag;
  logic [MW:0]      sum_full;
  logic             nxt_sign;
  logic [MW-1:0]    nxt_mag;
  logic             nxt_ovf;
  logic [CNT_W-1:0] nxt_cnt;
  logic [OUT_W-1:0] nxt_result;
  logic             nxt_sat;
  logic             out_big;

  assign accept   = iValid && (state != HOLD);
  assign oInReady = (state != HOLD);
  assign oValid   = (state == HOLD);

  always_comb begin
    // Starting a new sum is the same as adding the first term to +0.
    base_sign = (state == IDLE) ? 1'b0 : acc_sign;
    base_mag  = (state == IDLE) ? '0 : acc_mag;
    term_sign = iData[IN_W-1];
    term_mag  = {{(ACC_W-IN_W){1'b0}}, iData[IN_W-2:0]};
    sum_full  = {1'b0, base_mag} + {1'b0, term_mag};
    nxt_sign  = 1'b0;
    nxt_mag   = '0;
    nxt_ovf   = (state == IDLE) ? 1'b0 : ovf;
    if (base_sign == term_sign) begin
      nxt_sign = base_sign;
      if (sum_full[MW]) begin
        nxt_mag = '1;
        nxt_ovf = 1'b1;
      end else begin
        nxt_mag = sum_full[MW-1:0];
      end
    end else if (base_mag > term_mag) begin
      nxt_sign = base_sign;
      nxt_mag  = base_mag - term_mag;
    end else if (term_mag > base_mag) begin
      nxt_sign = term_sign;
      nxt_mag  = term_mag - base_mag;
    end
    if (nxt_mag == '0) nxt_sign = 1'b0;

    if (state == IDLE)   nxt_cnt = {{(CNT_W-1){1'b0}}, 1'b1};
    else if (cnt == '1)  nxt_cnt = cnt;
    else                 nxt_cnt = cnt + 1'b1;

    out_big = |nxt_mag[MW-1:OUT_W-1];
    if (out_big) begin
      nxt_result = {nxt_sign, {(OUT_W-1){1'b1}}};
      nxt_sat    = 1'b1;
    end else begin
      nxt_result = {nxt_sign, nxt_mag[OUT_W-2:0]};
      nxt_sat    = 1'b0;
    end
`ifdef SM_NEURON_ACCUM_RELU_EN
    if (nxt_sign) begin
      nxt_result = '0;
      nxt_sat    = 1'b0;
    end
`endif
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state    <= IDLE;
      acc_sign <= 1'b0;
      acc_mag  <= '0;
      ovf      <= 1'b0;
      cnt      <= '0;
      oResult  <= '0;
      oSat     <= 1'b0;
      oOvf     <= 1'b0;
      oCount   <= '0;
    end else begin
      case (state)
        IDLE, ACC: begin
          if (accept) begin
            acc_sign <= nxt_sign;
            acc_mag  <= nxt_mag;
            ovf      <= nxt_ovf;
            cnt      <= nxt_cnt;
            if (iLast) begin
              state   <= HOLD;
              oResult <= nxt_result;
              oSat    <= nxt_sat;
              oOvf    <= nxt_ovf;
              oCount  <= nxt_cnt;
            end else begin
              state <= ACC;
            end
          end
        end
        HOLD: begin
          if (iReady) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sm_neuron_accum.sv
// Directed self-checking bench for sm_neuron_accum with hand-computed expectations.
`timescale 1ns/1ps
module tb_sm_neuron_accum;

  logic       iClk = 1'b0;
  logic       iRst;
  logic [8:0] iData;
  logic       iValid;
  logic       iLast;
  logic       oInReady;
  logic [7:0] oResult;
  logic       oValid;
  logic       iReady;
  logic       oSat;
  logic       oOvf;
  logic [7:0] oCount;

  int total = 0;
  int passed = 0;

  sm_neuron_accum dut (
    .iClk(iClk), .iRst(iRst), .iData(iData), .iValid(iValid), .iLast(iLast),
    .oInReady(oInReady), .oResult(oResult), .oValid(oValid), .iReady(iReady),
    .oSat(oSat), .oOvf(oOvf), .oCount(oCount)
  );

  always #5 iClk = ~iClk;

  task automatic send(input logic [8:0] d, input logic last);
    iData = d; iValid = 1'b1; iLast = last;
    @(posedge iClk); #1;
    iValid = 1'b0; iLast = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge iClk);
    #1;
    total++; if (oValid !== 1'b0) $display("FAIL rst_valid got=%b exp=0", oValid); else passed++;
    total++; if (oInReady !== 1'b1) $display("FAIL rst_inready got=%b exp=1", oInReady); else passed++;
    total++; if (oResult !== 8'h00) $display("FAIL rst_result got=%h exp=00", oResult); else passed++;
    total++; if (oCount !== 8'd0) $display("FAIL rst_count got=%0d exp=0", oCount); else passed++;
    total++; if ({oSat, oOvf} !== 2'b00) $display("FAIL rst_flags got=%b exp=00", {oSat, oOvf}); else passed++;
    @(negedge iClk); iRst = 1'b0;
    @(posedge iClk); #1;
    total++; if (oInReady !== 1'b1) $display("FAIL rst_inready_after got=%b exp=1", oInReady); else passed++;
    $display("reset: checked idle outputs");
  endtask

  task automatic test_basic;
    send(9'h005, 1'b0);
    send(9'h103, 1'b0);
    iLast = 1'b1;
    @(posedge iClk); #1;
    iLast = 1'b0;
    total++; if (oValid !== 1'b0) $display("FAIL lone_last_valid got=%b exp=0", oValid); else passed++;
    send(9'h00A, 1'b1);
    total++; if (oValid !== 1'b1) $display("FAIL basic_valid got=%b exp=1", oValid); else passed++;
    total++; if (oResult !== 8'h0C) $display("FAIL basic_result got=%h exp=0c", oResult); else passed++;
    total++; if (oCount !== 8'd3) $display("FAIL basic_count got=%0d exp=3", oCount); else passed++;
    total++; if ({oSat, oOvf} !== 2'b00) $display("FAIL basic_flags got=%b exp=00", {oSat, oOvf}); else passed++;
    @(posedge iClk); #1;
    total++; if (oValid !== 1'b0) $display("FAIL basic_drain got=%b exp=0", oValid); else passed++;
    $display("basic: +5 -3 +10 -> result=%h count=%0d", oResult, oCount);
  endtask

  task automatic test_sat;
    logic [7:0] exp_neg;
    logic       exp_neg_sat;
`ifdef SM_NEURON_ACCUM_RELU_EN
    exp_neg = 8'h00; exp_neg_sat = 1'b0;
`else
    exp_neg = 8'hFF; exp_neg_sat = 1'b1;
`endif
    for (int i = 0; i < 4; i++) send(9'h0FF, i == 3);
    total++; if (oResult !== 8'h7F) $display("FAIL sat_pos_result got=%h exp=7f", oResult); else passed++;
    total++; if (oSat !== 1'b1) $display("FAIL sat_pos_sat got=%b exp=1", oSat); else passed++;
    total++; if (oCount !== 8'd4) $display("FAIL sat_pos_count got=%0d exp=4", oCount); else passed++;
    @(posedge iClk); #1;
    for (int i = 0; i < 4; i++) send(9'h1FF, i == 3);
    total++; if (oResult !== exp_neg) $display("FAIL sat_neg_result got=%h exp=%h", oResult, exp_neg); else passed++;
    total++; if (oSat !== exp_neg_sat) $display("FAIL sat_neg_sat got=%b exp=%b", oSat, exp_neg_sat); else passed++;
    total++; if (oOvf !== 1'b0) $display("FAIL sat_neg_ovf got=%b exp=0", oOvf); else passed++;
    @(posedge iClk); #1;
    $display("sat: 4x(+/-255) -> last result=%h", oResult);
  endtask

  task automatic test_zero;
    send(9'h107, 1'b0);
    send(9'h007, 1'b1);
    total++; if (oResult !== 8'h00) $display("FAIL zero_cancel_result got=%h exp=00", oResult); else passed++;
    total++; if (oSat !== 1'b0) $display("FAIL zero_cancel_sat got=%b exp=0", oSat); else passed++;
    @(posedge iClk); #1;
    send(9'h100, 1'b1);
    total++; if (oResult !== 8'h00) $display("FAIL neg_zero_result got=%h exp=00", oResult); else passed++;
    total++; if (oCount !== 8'd1) $display("FAIL neg_zero_count got=%0d exp=1", oCount); else passed++;
    @(posedge iClk); #1;
    $display("zero: -7+7 and -0 -> result=%h", oResult);
  endtask

  task automatic test_ovf;
    for (int i = 0; i < 129; i++) send(9'h0FF, i == 128);
    total++; if (oOvf !== 1'b1) $display("FAIL ovf_flag got=%b exp=1", oOvf); else passed++;
    total++; if (oSat !== 1'b1) $display("FAIL ovf_sat got=%b exp=1", oSat); else passed++;
    total++; if (oResult !== 8'h7F) $display("FAIL ovf_result got=%h exp=7f", oResult); else passed++;
    total++; if (oCount !== 8'd129) $display("FAIL ovf_count got=%0d exp=129", oCount); else passed++;
    @(posedge iClk); #1;
    send(9'h001, 1'b1);
    total++; if (oOvf !== 1'b0) $display("FAIL ovf_clear got=%b exp=0", oOvf); else passed++;
    total++; if (oResult !== 8'h01) $display("FAIL ovf_next_result got=%h exp=01", oResult); else passed++;
    @(posedge iClk); #1;
    $display("ovf: 129x255 then +1 -> result=%h ovf=%b", oResult, oOvf);
  endtask

  task automatic test_cnt_sat;
    for (int i = 0; i < 300; i++) send(9'h000, i == 299);
    total++; if (oCount !== 8'd255) $display("FAIL cnt_sat got=%0d exp=255", oCount); else passed++;
    total++; if (oResult !== 8'h00) $display("FAIL cnt_sat_result got=%h exp=00", oResult); else passed++;
    @(posedge iClk); #1;
    $display("cnt_sat: 300 terms -> count=%0d", oCount);
  endtask

  task automatic test_back_to_back;
    iReady = 1'b0;
    send(9'h001, 1'b0);
    send(9'h002, 1'b1);
    iData = 9'h004; iValid = 1'b1; iLast = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge iClk); #1;
      total++; if (oValid !== 1'b1) $display("FAIL bp_valid[%0d] got=%b exp=1", i, oValid); else passed++;
      total++; if (oResult !== 8'h03) $display("FAIL bp_result[%0d] got=%h exp=03", i, oResult); else passed++;
      total++; if (oInReady !== 1'b0) $display("FAIL bp_inready[%0d] got=%b exp=0", i, oInReady); else passed++;
      total++; if (oCount !== 8'd2) $display("FAIL bp_count[%0d] got=%0d exp=2", i, oCount); else passed++;
    end
    iReady = 1'b1;
    @(posedge iClk); #1;
    total++; if (oValid !== 1'b0) $display("FAIL bp_release_valid got=%b exp=0", oValid); else passed++;
    total++; if (oInReady !== 1'b1) $display("FAIL bp_release_inready got=%b exp=1", oInReady); else passed++;
    @(posedge iClk); #1;
    iValid = 1'b0; iLast = 1'b0;
    total++; if (oResult !== 8'h04) $display("FAIL bp_pending_result got=%h exp=04", oResult); else passed++;
    total++; if (oCount !== 8'd1) $display("FAIL bp_pending_count got=%0d exp=1", oCount); else passed++;
    @(posedge iClk); #1;
    $display("back_to_back: pending term -> result=%h count=%0d", oResult, oCount);
  endtask

  task automatic test_reset_mid;
    send(9'h005, 1'b0);
    send(9'h006, 1'b0);
    #2 iRst = 1'b1;
    #1;
    total++; if (oResult !== 8'h00) $display("FAIL rstmid_result got=%h exp=00", oResult); else passed++;
    total++; if (oCount !== 8'd0) $display("FAIL rstmid_count got=%0d exp=0", oCount); else passed++;
    total++; if (oInReady !== 1'b1) $display("FAIL rstmid_inready got=%b exp=1", oInReady); else passed++;
    total++; if (oValid !== 1'b0) $display("FAIL rstmid_valid got=%b exp=0", oValid); else passed++;
    @(negedge iClk); iRst = 1'b0;
    send(9'h009, 1'b1);
    total++; if (oResult !== 8'h09) $display("FAIL rstmid_fresh_result got=%h exp=09", oResult); else passed++;
    total++; if (oCount !== 8'd1) $display("FAIL rstmid_fresh_count got=%0d exp=1", oCount); else passed++;
    @(posedge iClk); #1;
    $display("reset_mid: fresh +9 -> result=%h count=%0d", oResult, oCount);
  endtask

  initial begin
    iRst = 1'b1; iData = '0; iValid = 1'b0; iLast = 1'b0; iReady = 1'b1;
    test_reset;
    test_basic;
    test_sat;
    test_zero;
    test_ovf;
    test_cnt_sat;
    test_back_to_back;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
